// File: rtl/program_sequencer.sv
// Instruction sequencer: fetches the word at PC, decodes it and drives jump
// strobes, the condition flag and an accumulator for the program counter.
module program_sequencer #(
  parameter int N = 8,
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] PC,
  output logic         instr_req,
  output logic [N-1:0] instr_addr,
  input  logic         instr_valid,
  input  logic [W-1:0] instr_data,
  output logic [N-1:0] addr,
  output logic         JP,
  output logic         JF,
  output logic         Flag,
  output logic         pc_step,
  output logic         halted,
  output logic         illegal,
  output logic [1:0]   dbg_state,
  output logic [N-1:0] dbg_acc
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_JMP   = 4'd1;
  localparam logic [3:0] OP_JMPF  = 4'd2;
  localparam logic [3:0] OP_SETF  = 4'd3;
  localparam logic [3:0] OP_CLRF  = 4'd4;
  localparam logic [3:0] OP_LOAD  = 4'd5;
  localparam logic [3:0] OP_ADD   = 4'd6;
  localparam logic [3:0] OP_CMPEQ = 4'd7;
  localparam logic [3:0] OP_HALT  = 4'd15;

  state_t       state_q, state_d;
  logic [3:0]   op_q;
  logic [N-1:0] operand_q;
  logic [N-1:0] acc_q, acc_d;
  logic         flag_q, flag_d;
  logic [N:0]   sum;

  // Only the opcode and operand fields of the word are meaningful.
  logic unused_bits;
  assign unused_bits = ^instr_data[W-5:N];

  // Handshake: a fetch completes in any cycle where instr_req and
  // instr_valid are both high; instr_valid is ignored while instr_req is low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= OP_NOP;
      operand_q <= '0;
      acc_q     <= '0;
      flag_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      flag_q  <= flag_d;
      if (state_q == S_FETCH && instr_valid) begin
        op_q      <= instr_data[W-1:W-4];
        operand_q <= instr_data[N-1:0];
      end
    end
  end

  assign sum        = {1'b0, acc_q} + {1'b0, operand_q};
  assign instr_addr = PC;
  assign Flag       = flag_q;
  assign dbg_state  = state_q;
  assign dbg_acc    = acc_q;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    flag_d    = flag_q;
    instr_req = 1'b0;
    addr      = '0;
    JP        = 1'b0;
    JF        = 1'b0;
    pc_step   = 1'b0;
    halted    = 1'b0;
    illegal   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        instr_req = 1'b1;
        if (instr_valid) state_d = S_EXEC;
      end
      S_EXEC: begin
        pc_step = 1'b1;
        state_d = S_FETCH;
        case (op_q)
          OP_NOP: ;
          OP_JMP: begin
            JP   = 1'b1;
            addr = operand_q;
          end
          // The program counter qualifies JF with the pre-EXEC Flag.
          OP_JMPF: begin
            JF   = 1'b1;
            addr = operand_q;
          end
          OP_SETF:  flag_d = 1'b1;
          OP_CLRF:  flag_d = 1'b0;
          OP_LOAD:  acc_d  = operand_q;
          OP_ADD:   {flag_d, acc_d} = sum;
          OP_CMPEQ: flag_d = (acc_q == operand_q);
          OP_HALT: begin
            pc_step = 1'b0;
            state_d = S_HALT;
          end
          default:  illegal = 1'b1;
        endcase
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: doc/program_sequencer.md
Name: program_sequencer

Overview:
- Drives the program counter: fetches the instruction word at the current PC, decodes it, and returns jump controls (JP, JF, addr) plus the condition Flag.
- Holds an N-bit accumulator and the flag register.
- Sits between instruction memory (request/valid read port) and the program counter.
- Produces a one-cycle pc_step strobe per executed instruction; the program counter updates only on that strobe.

Parameters:
- N, 8, address/PC and accumulator width.
- W, 16, instruction word width; W >= N+4; opcode = instr[W-1:W-4], operand = instr[N-1:0], remaining bits ignored.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  leave IDLE and begin fetching.
- PC  in  N  current program counter value.
- instr_req  out  1  instruction read request.
- instr_addr  out  N  read address.
- instr_valid  in  1  read data valid; ignored while instr_req=0.
- instr_data  in  W  instruction word, sampled when instr_req & instr_valid.
- addr  out  N  jump target to program counter.
- JP  out  1  unconditional jump strobe.
- JF  out  1  jump-if-Flag strobe.
- Flag  out  1  registered condition flag.
- pc_step  out  1  program counter update strobe.
- halted  out  1  high in HALT state.
- illegal  out  1  one-cycle pulse on undefined opcode.

Behaviour:
- Reset (rst_n=0 at a rising edge), regardless of state:
  - state=IDLE, acc=0, Flag=0.
  - instr_req, JP, JF, pc_step, illegal, halted all 0; addr=0.
  - An outstanding fetch is abandoned; a later instr_valid is ignored.
- FSM states: IDLE, FETCH, EXEC, HALT.
- IDLE: outputs inactive. start=1 -> FETCH next cycle.
- FETCH:
  - instr_req=1, instr_addr=PC, combinational from PC.
  - Stays in FETCH while instr_valid=0; no timeout.
  - instr_valid=1 in the same cycle the request is high: instr_data is latched into the instruction register and the FSM goes to EXEC. Zero-wait memory therefore costs 1 cycle.
- EXEC:
  - Exactly one cycle; instr_req=0.
  - Decode uses the latched word. Strobes are combinational from the latched word and valid only in EXEC.
  - acc and Flag update at the end of the EXEC cycle.
  - pc_step=1 for every opcode except HALT; the FSM then returns to FETCH.
- Opcodes:
  - 0 NOP: no effect.
  - 1 JMP: JP=1, addr=operand.
  - 2 JMPF: JF=1, addr=operand. The program counter jumps only if Flag is set; Flag is the pre-EXEC registered value.
  - 3 SETF: Flag<=1.
  - 4 CLRF: Flag<=0.
  - 5 LOAD: acc<=operand; Flag unchanged.
  - 6 ADD: {Flag,acc}<=acc+operand as an (N+1)-bit sum, i.e. Flag=carry out. acc wraps modulo 2^N.
  - 7 CMPEQ: Flag<=(acc==operand).
  - 15 HALT: no pc_step; the FSM goes to HALT.
  - 8-14 illegal: illegal=1 for the EXEC cycle, otherwise executed as NOP (pc_step=1).
- Strobe rules:
  - JP and JF are never both 1.
  - addr=0 whenever JP=0 and JF=0.
- HALT:
  - halted=1 and all strobes 0.
  - Left only by reset; start is ignored.
- start is ignored in every state except IDLE.
- Throughput: 2 cycles per instruction with zero-wait memory; 2+k cycles with k wait cycles.

Test Plan:
- Reset, then start, zero-wait memory returning 0x0000 (NOP) at PC=0:
  - instr_req=1 with instr_addr=0 on cycle 1.
  - pc_step=1 on cycle 2 with JP=JF=0.
  - Pattern repeats every 2 cycles.
- LOAD 0xFE then ADD 0x03 (0x50FE, 0x6003) -> acc=0x01, Flag=1 after the ADD EXEC. Follow with JMPF 0x40 (0x2040) -> JF=1, addr=0x40, Flag=1.
- CMPEQ mismatch then JMP: acc=0x05, CMPEQ 0x06 -> Flag=0. JMP 0x10 (0x1010) -> JP=1, addr=0x10, JF=0.
- Memory inserts 3 wait cycles (instr_valid low) -> instr_req held high 4 cycles with a stable instr_addr; EXEC occurs exactly one cycle after valid.
- Opcode 0x9 -> illegal=1 and pc_step=1 for one cycle. Opcode 0xF -> halted=1, no pc_step, and a subsequent start=1 has no effect.
- rst_n=0 during a FETCH wait, then instr_valid asserted after reset -> state IDLE, instr_req=0, acc=0, Flag=0, no EXEC strobes.
